// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder built from one full-adder cell and a
// carry flip-flop. Operands are accepted on a start pulse and processed
// LSB-first, one bit per clock. The registered result and carry-out are
// presented with a one-cycle done pulse.
//
// Optional feature macro: SERIAL_SUB_EN adds the mode port. With mode=1 the
// block subtracts (a - b - cin) and cout reports a borrow.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request pulse, honoured in IDLE or DONE
//   a, b   in   WIDTH-bit operands, sampled on the accepting edge
//   cin    in   carry-in (borrow-in when subtracting)
//   mode   in   SERIAL_SUB_EN only: 0 = add, 1 = subtract
//   busy   out  high while bits are being processed
//   done   out  one-cycle completion pulse
//   sum    out  WIDTH-bit result of the last completed operation
//   cout   out  carry-out (borrow-out when subtracting)
//
// state | meaning
// IDLE  | waiting for start
// RUN   | processing one bit per clock, counter = bit index
// DONE  | result just loaded; done pulse; may accept start again
module serial_adder #(
  parameter int WIDTH = 8  // legal range 2..32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_SUB_EN
  input  logic             mode,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] s_sr_q, s_sr_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             s_bit;
  logic             c_next;
  logic [WIDTH-1:0] s_shift;
  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic             cout_fix;

`ifdef SERIAL_SUB_EN
  // Subtraction is a + ~b + ~cin; the final carry is inverted to read as a
  // borrow, so the mode of the operation in flight must be remembered.
  logic sub_q, sub_d;
  assign b_load   = mode ? ~b : b;
  assign c_load   = mode ^ cin;
  assign cout_fix = sub_q;
`else
  assign b_load   = b;
  assign c_load   = cin;
  assign cout_fix = 1'b0;
`endif

  assign s_bit   = a_sr_q[0] ^ b_sr_q[0] ^ c_q;
  assign c_next  = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & c_q) | (b_sr_q[0] & c_q);
  assign s_shift = {s_bit, s_sr_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    s_sr_d  = s_sr_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_SUB_EN
    sub_d   = sub_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b_load;
          c_d     = c_load;
          cnt_d   = '0;
          state_d = RUN;
`ifdef SERIAL_SUB_EN
          sub_d   = mode;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        c_d    = c_next;
        a_sr_d = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
        s_sr_d = s_shift;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          sum_d   = s_shift;
          cout_d  = c_next ^ cout_fix;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      s_sr_q  <= s_sr_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  // busy/done are decodes of the state flop only; no input reaches them.
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef SERIAL_SUB_EN
  logic         mode;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_prev;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_SUB_EN
    .mode  (mode),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         mode;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Drives one operation from a negedge and follows it to the done pulse,
  // checking latency, busy length, result hold during RUN, and pulse width.
  task automatic run_op(input vec_t v);
    int cycles;
    int nbusy;
    logic held_ok;
    a     = v.a;
    b     = v.b;
    cin   = v.cin;
`ifdef SERIAL_SUB_EN
    mode  = v.mode;
`endif
    start = 1'b1;
    @(posedge clk);
    cycles = 1;
    nbusy = 0;
    held_ok = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!done && cycles < 20) begin
      if (busy) nbusy++;
      if (sum !== exp_prev) held_ok = 1'b0;
      @(posedge clk);
      cycles++;
      @(negedge clk);
    end
    chk("latency", cycles, W + 1);
    chk("busy_cycles", nbusy, W);
    chk("sum_held", {31'd0, held_ok}, 32'd1);
    chk("busy_in_done", {31'd0, busy}, 32'd0);
    chk("sum", {24'd0, sum}, {24'd0, v.exp_sum});
    chk("cout", {31'd0, cout}, {31'd0, v.exp_cout});
    exp_prev = v.exp_sum;
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[6];
    int nd;
    int t1;
    int t2;

    tbl[0] = '{a: 8'h5A, b: 8'h3C, cin: 1'b0, mode: 1'b0, exp_sum: 8'h96, exp_cout: 1'b0};
    tbl[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b1, mode: 1'b0, exp_sum: 8'h01, exp_cout: 1'b1};
    tbl[2] = '{a: 8'h01, b: 8'h02, cin: 1'b0, mode: 1'b0, exp_sum: 8'h03, exp_cout: 1'b0};
    tbl[3] = '{a: 8'h00, b: 8'h00, cin: 1'b1, mode: 1'b0, exp_sum: 8'h01, exp_cout: 1'b0};
    tbl[4] = '{a: 8'h80, b: 8'h80, cin: 1'b0, mode: 1'b0, exp_sum: 8'h00, exp_cout: 1'b1};
    tbl[5] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, mode: 1'b0, exp_sum: 8'hFF, exp_cout: 1'b1};

    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
`ifdef SERIAL_SUB_EN
    mode = 1'b0;
`endif
    exp_prev = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sum", {24'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_op(tbl[i]);

    // Reset in the middle of an operation, after a result with cout=1.
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_sum", {24'd0, sum}, 32'd0);
    chk("midrst_cout", {31'd0, cout}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("midrst_no_done", nd, 0);
    exp_prev = '0;
    run_op(tbl[0]);

    // Start pulsed during RUN must be ignored.
    a = 8'h5A; b = 8'h3C; cin = 1'b0; start = 1'b1;
    nd = 0;
    t1 = 0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        t1 = i;
      end
      start = (i == 3);
      if (i == 3) begin
        a = 8'h00; b = 8'h00;
      end
    end
    chk("ign_done_count", nd, 1);
    chk("ign_latency", t1, W + 1);
    chk("ign_sum", {24'd0, sum}, 32'h96);
    chk("ign_cout", {31'd0, cout}, 32'd0);

    // Back-to-back: start held in the DONE cycle.
    a = 8'hFF; b = 8'h01; cin = 1'b1; start = 1'b1;
    nd = 0;
    t1 = 0;
    t2 = 0;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      if (i == t1 + 1 && t1 != 0) chk("b2b_no_idle", {31'd0, busy}, 32'd1);
      start = 1'b0;
      if (done) begin
        nd++;
        if (nd == 1) begin
          t1 = i;
          chk("b2b_sum1", {24'd0, sum}, 32'h01);
          chk("b2b_cout1", {31'd0, cout}, 32'd1);
          a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
        end else if (nd == 2) begin
          t2 = i;
          chk("b2b_sum2", {24'd0, sum}, 32'h03);
          chk("b2b_cout2", {31'd0, cout}, 32'd0);
        end
      end
    end
    chk("b2b_done_count", nd, 2);
    chk("b2b_spacing", t2 - t1, W + 1);
    exp_prev = 8'h03;

`ifdef SERIAL_SUB_EN
    run_op('{a: 8'h10, b: 8'h20, cin: 1'b0, mode: 1'b1, exp_sum: 8'hF0, exp_cout: 1'b1});
    run_op('{a: 8'h20, b: 8'h10, cin: 1'b1, mode: 1'b1, exp_sum: 8'h0F, exp_cout: 1'b0});
    run_op('{a: 8'h5A, b: 8'h3C, cin: 1'b0, mode: 1'b0, exp_sum: 8'h96, exp_cout: 1'b0});
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
